// File: rtl/axon_pkg.sv
// rtl/axon_pkg.sv - shared constants and timestamp type for the axon delay line
package axon_pkg;
  localparam int DFLT_DELAY_W = 6;
  localparam int DROP_CNT_W   = 16;

  typedef logic [DFLT_DELAY_W-1:0] axon_ts_t;
endpackage

// File: rtl/axon_ts_fifo.sv
// rtl/axon_ts_fifo.sv - in-order FIFO of spike due timestamps
// Push is accepted when not full, or when a pop happens on the same edge.
module axon_ts_fifo
  import axon_pkg::*;
#(
  parameter int WIDTH = $bits(axon_ts_t),
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read out.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axon_delay_line.sv
// rtl/axon_delay_line.sv - programmable multi-spike axonal delay line
// Optional drop counter port enabled by AXON_DELAY_DROP_CNT_EN.
module axon_delay_line
  import axon_pkg::*;
#(
  parameter int DELAY_W       = DFLT_DELAY_W,
  parameter int DEPTH         = 8,
  parameter int DEFAULT_DELAY = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               spike_in,
  input  logic               delay_wr,
  input  logic [DELAY_W-1:0] delay_in,
  output logic               spike_out,
  output logic               busy,
  output logic [OCC_W-1:0]   occupancy,
  output logic               drop,
`ifdef AXON_DELAY_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_count,
`endif
  output logic               delay_err
);

  logic [DELAY_W-1:0] now_q, now_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic               spike_out_q, spike_out_d;
  logic               drop_q, drop_d;
  logic               delay_err_q, delay_err_d;

  logic [DELAY_W-1:0] head;
  logic [OCC_W-1:0]   count;
  logic               full, empty;
  logic               pop, wr_ok;

  axon_ts_fifo #(
    .WIDTH (DELAY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (spike_in),
    .push_data (now_q + delay_q),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Due stamps are strictly increasing, so only the head can ever be due.
  assign pop   = !empty && (head == now_q);
  assign wr_ok = delay_wr && empty && (delay_in != '0);

  always_comb begin
    now_d       = now_q + DELAY_W'(1);
    delay_d     = wr_ok ? delay_in : delay_q;
    spike_out_d = pop;
    drop_d      = spike_in && full && !pop;
    delay_err_d = delay_wr && !wr_ok;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      now_q       <= '0;
      delay_q     <= DELAY_W'(DEFAULT_DELAY);
      spike_out_q <= 1'b0;
      drop_q      <= 1'b0;
      delay_err_q <= 1'b0;
    end else begin
      now_q       <= now_d;
      delay_q     <= delay_d;
      spike_out_q <= spike_out_d;
      drop_q      <= drop_d;
      delay_err_q <= delay_err_d;
    end
  end

`ifdef AXON_DELAY_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  assign spike_out = spike_out_q;
  assign drop      = drop_q;
  assign delay_err = delay_err_q;
  assign occupancy = count;
  assign busy      = (count != '0);

endmodule

// File: tb/tb_axon_delay_line.sv
// tb/tb_axon_delay_line.sv - directed self-checking bench for axon_delay_line
module tb_axon_delay_line;

  logic       clock;
  logic       reset;
  logic       spike_in;
  logic       delay_wr;
  logic [5:0] delay_in;
  logic       spike_out;
  logic       busy;
  logic [3:0] occupancy;
  logic       drop;
  logic       delay_err;
`ifdef AXON_DELAY_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  axon_delay_line #(
    .DELAY_W       (6),
    .DEPTH         (8),
    .DEFAULT_DELAY (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .spike_in   (spike_in),
    .delay_wr   (delay_wr),
    .delay_in   (delay_in),
    .spike_out  (spike_out),
    .busy       (busy),
    .occupancy  (occupancy),
    .drop       (drop),
`ifdef AXON_DELAY_DROP_CNT_EN
    .drop_count (drop_count),
`endif
    .delay_err  (delay_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ec = 0;
  int ec_rst = 0;
  int e0 = 0;
  bit exp_at [0:1023];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    ec++;
    chk($sformatf("spike_out@%0d", ec), int'(spike_out), int'(exp_at[ec]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic spike(input int n, input int d);
    for (int i = 0; i < n; i++) begin
      spike_in = 1'b1;
      exp_at[ec + 1 + d] = 1'b1;
      step();
    end
    spike_in = 1'b0;
  endtask

  task automatic write_delay(input int v);
    delay_wr = 1'b1;
    delay_in = 6'(v);
    step();
    delay_wr = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
    ec_rst = ec;
  endtask

  initial begin
    reset    = 1'b1;
    spike_in = 1'b0;
    delay_wr = 1'b0;
    delay_in = '0;
    do_reset(2);
    chk("rst_spike_out", int'(spike_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_drop", int'(drop), 0);
    chk("rst_delay_err", int'(delay_err), 0);
    idle(7);

    // default delay 4
    spike(1, 4);
    chk("t1_occ_in", int'(occupancy), 1);
    chk("t1_busy_in", int'(busy), 1);
    idle(4);
    chk("t1_occ_out", int'(occupancy), 0);
    idle(2);

    // delay 7 burst of 5
    write_delay(7);
    chk("t2_wr_err", int'(delay_err), 0);
    spike(5, 7);
    chk("t2_occ_peak", int'(occupancy), 5);
    idle(12);
    chk("t2_occ_end", int'(occupancy), 0);
    chk("t2_busy_end", int'(busy), 0);

    // rejected writes
    spike(2, 7);
    write_delay(3);
    chk("t4_err_busy", int'(delay_err), 1);
    chk("t4_occ", int'(occupancy), 2);
    step();
    chk("t4_err_clear", int'(delay_err), 0);
    idle(8);
    write_delay(0);
    chk("t4_err_zero", int'(delay_err), 1);
    spike(1, 7);
    idle(8);

    // write with same-edge spike: spike keeps old delay 7, new delay 5 after
    delay_wr = 1'b1;
    delay_in = 6'd5;
    spike(1, 7);
    delay_wr = 1'b0;
    chk("t4_same_edge_err", int'(delay_err), 0);
    idle(9);
    spike(1, 5);
    idle(6);

    // wrap of now: inject at now = 61,62,63,0
    for (int i = 0; i < 64; i++) begin
      if ((ec - ec_rst) % 64 != 61) step();
    end
    spike(4, 5);
    idle(8);
    chk("t5_occ_end", int'(occupancy), 0);

    // full queue with delay 63
    write_delay(63);
    e0 = ec + 1;
    spike(8, 63);
    chk("t3_occ_full", int'(occupancy), 8);
    chk("t3_no_drop", int'(drop), 0);
    spike_in = 1'b1;
    step();
    chk("t3_drop9", int'(drop), 1);
    step();
    chk("t3_drop10", int'(drop), 1);
    spike_in = 1'b0;
    step();
    chk("t3_drop_clear", int'(drop), 0);
    chk("t3_occ_after_drop", int'(occupancy), 8);
`ifdef AXON_DELAY_DROP_CNT_EN
    chk("t3_drop_count", int'(drop_count), 2);
`endif
    idle(e0 + 62 - ec);
    spike(1, 63);
    chk("t3_full_pushpop_drop", int'(drop), 0);
    chk("t3_full_pushpop_occ", int'(occupancy), 8);
    idle(66);
    chk("t3_occ_end", int'(occupancy), 0);

    // reset flushes in-flight spikes and restores default delay
    write_delay(10);
    spike_in = 1'b1;
    idle(3);
    spike_in = 1'b0;
    chk("t6_occ_pre", int'(occupancy), 3);
    do_reset(1);
    chk("t6_occ_rst", int'(occupancy), 0);
    chk("t6_busy_rst", int'(busy), 0);
    idle(15);
    chk("t6_occ_after", int'(occupancy), 0);
    spike(1, 4);
    idle(6);
    chk("t6_occ_end", int'(occupancy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
